// File: rtl/bitreversal_reg_pkg.sv
// Shared types for the bit-reversal accelerator register interface and its OBI bridge.
// Single-cycle-free package: types, bridge state encoding and timeout counter width.
package bitreversal_reg_pkg;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } reg_req_t;

   typedef struct packed {
      logic        error;
      logic        ready;
      logic [31:0] rdata;
   } reg_resp_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } obi_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } bridge_state_e;

   localparam int BRIDGE_TIMEOUT_W = 16;

endpackage

// File: rtl/bitreversal_reg_timeout_cnt.sv
// ACCESS-phase watchdog: clears on clr_i, counts on en_i, flags tc_o at TERMINAL.
// Zero-latency terminal flag from the registered count; no backpressure.
module bitreversal_reg_timeout_cnt
   import bitreversal_reg_pkg::*;
#(
   parameter int unsigned TERMINAL = 254
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [BRIDGE_TIMEOUT_W-1:0] TC_VAL = BRIDGE_TIMEOUT_W'(TERMINAL);

   logic [BRIDGE_TIMEOUT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/bitreversal_obi_reg_bridge.sv
// OBI slave to reg_req_t bridge, one outstanding access, >=3 cycles per transaction.
// Grant only in IDLE; waits on reg ready (abort after TIMEOUT_CYCLES if BITREV_OBI_REG_TIMEOUT_EN).
module bitreversal_obi_reg_bridge
   import bitreversal_reg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        obi_req_i,
   output logic        obi_gnt_o,
   input  logic [31:0] obi_addr_i,
   input  logic        obi_we_i,
   input  logic [3:0]  obi_be_i,
   input  logic [31:0] obi_wdata_i,
   output logic        obi_rvalid_o,
   output logic [31:0] obi_rdata_o,
   output logic        obi_err_o,
   output reg_req_t    reg_req_o,
   input  reg_resp_t   reg_rsp_i
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   bridge_state_e state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic          accept;
   logic          timeout_hit;

   assign obi_gnt_o = (state_q == IDLE) && !rst_i;
   assign accept    = obi_req_i && obi_gnt_o;

`ifdef BITREV_OBI_REG_TIMEOUT_EN
   logic cnt_tc;

   bitreversal_reg_timeout_cnt #(
      .TERMINAL(TIMEOUT_CYCLES - 1)
   ) u_timeout_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (accept),
      .en_i  ((state_q == ACCESS) && !reg_rsp_i.ready),
      .tc_o  (cnt_tc)
   );

   assign timeout_hit = (state_q == ACCESS) && cnt_tc;
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = obi_addr_i;
               wdata_d = obi_wdata_i;
               we_d    = obi_we_i;
               wstrb_d = obi_we_i ? obi_be_i : 4'b0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // Ready takes priority over a coincident timeout.
            if (reg_rsp_i.ready) begin
               rdata_d = we_q ? 32'h0 : reg_rsp_i.rdata;
               err_d   = reg_rsp_i.error;
               state_d = RESP;
            end else if (timeout_hit) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      reg_req_o = '0;
      if (state_q == ACCESS) begin
         reg_req_o.valid = 1'b1;
         reg_req_o.write = we_q;
         reg_req_o.wstrb = wstrb_q;
         reg_req_o.addr  = addr_q;
         reg_req_o.wdata = wdata_q;
      end
   end

   assign obi_rvalid_o = (state_q == RESP);
   assign obi_rdata_o  = obi_rvalid_o ? rdata_q : 32'h0;
   assign obi_err_o    = obi_rvalid_o ? err_q : 1'b0;

endmodule

// File: tb/tb_bitreversal_obi_reg_bridge.sv
// Self-checking bench for bitreversal_obi_reg_bridge: vector table plus response scoreboard.
module tb_bitreversal_obi_reg_bridge;
   import bitreversal_reg_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        obi_req_i;
   logic        obi_gnt_o;
   logic [31:0] obi_addr_i;
   logic        obi_we_i;
   logic [3:0]  obi_be_i;
   logic [31:0] obi_wdata_i;
   logic        obi_rvalid_o;
   logic [31:0] obi_rdata_o;
   logic        obi_err_o;
   reg_req_t    reg_req;
   reg_resp_t   reg_rsp;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rsp_rdata;
      logic        rsp_err;
      int          delay;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t        tbl[6];
   logic [32:0] sb_q[$];

   bitreversal_obi_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .obi_req_i    (obi_req_i),
      .obi_gnt_o    (obi_gnt_o),
      .obi_addr_i   (obi_addr_i),
      .obi_we_i     (obi_we_i),
      .obi_be_i     (obi_be_i),
      .obi_wdata_i  (obi_wdata_i),
      .obi_rvalid_o (obi_rvalid_o),
      .obi_rdata_o  (obi_rdata_o),
      .obi_err_o    (obi_err_o),
      .reg_req_o    (reg_req),
      .reg_rsp_i    (reg_rsp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every rvalid pops one expected {err, rdata}.
   always @(negedge clk) begin
      logic [32:0] e;
      if (obi_rvalid_o) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rvalid", 64'(obi_rvalid_o), 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("resp_rdata", 64'(obi_rdata_o), 64'(e[31:0]));
            chk("resp_err", 64'(obi_err_o), 64'(e[32]));
         end
      end else begin
         chk("idle_rdata_zero", 64'(obi_rdata_o), 64'd0);
         chk("idle_err_zero", 64'(obi_err_o), 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1 with the bridge in IDLE.
   task automatic do_txn(input vec_t v, input bit hold);
      int n;
      obi_req_i   = 1'b1;
      obi_addr_i  = v.addr;
      obi_we_i    = v.we;
      obi_be_i    = v.be;
      obi_wdata_i = v.wdata;
      chk("gnt_idle", 64'(obi_gnt_o), 64'd1);
      sb_q.push_back({v.exp_err, v.exp_rdata});
      tick();
      if (!hold) begin
         obi_req_i   = 1'b0;
         obi_addr_i  = ~v.addr;
         obi_we_i    = ~v.we;
         obi_be_i    = ~v.be;
         obi_wdata_i = ~v.wdata;
      end
      n = (v.delay < 0) ? TO : v.delay + 1;
      for (int k = 0; k < n; k++) begin
         chk("acc_valid", 64'(reg_req.valid), 64'd1);
         chk("acc_write", 64'(reg_req.write), 64'(v.we));
         chk("acc_wstrb", 64'(reg_req.wstrb), 64'(v.we ? v.be : 4'h0));
         chk("acc_addr", 64'(reg_req.addr), 64'(v.addr));
         chk("acc_wdata", 64'(reg_req.wdata), 64'(v.wdata));
         chk("acc_gnt", 64'(obi_gnt_o), 64'd0);
         chk("acc_rvalid", 64'(obi_rvalid_o), 64'd0);
         reg_rsp.ready = (v.delay >= 0) && (k == v.delay);
         reg_rsp.rdata = reg_rsp.ready ? v.rsp_rdata : 32'h5A5A_0000 + 32'(k);
         reg_rsp.error = reg_rsp.ready ? v.rsp_err : 1'b1;
         tick();
      end
      chk("resp_rvalid", 64'(obi_rvalid_o), 64'd1);
      chk("resp_valid_drop", 64'(reg_req.valid), 64'd0);
      chk("resp_gnt", 64'(obi_gnt_o), 64'd0);
      // Stray ready during RESP must be ignored.
      reg_rsp.ready = 1'b1;
      reg_rsp.error = 1'b1;
      reg_rsp.rdata = 32'hFFFF_0000;
      tick();
      reg_rsp = '0;
      chk("post_rvalid", 64'(obi_rvalid_o), 64'd0);
      chk("post_valid", 64'(reg_req.valid), 64'd0);
   endtask

   initial begin
      tbl[0] = '{32'h0000_0008, 1'b0, 4'hF, 32'h0,         32'hA5A5_1234, 1'b0, 0, 32'hA5A5_1234, 1'b0};
      tbl[1] = '{32'h0000_0004, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h1111_2222, 1'b0, 3, 32'h0,         1'b0};
      tbl[2] = '{32'h0000_0010, 1'b0, 4'hF, 32'h0,         32'h0BAD_0BAD, 1'b1, 1, 32'h0BAD_0BAD, 1'b1};
      tbl[3] = '{32'h0000_0003, 1'b1, 4'h0, 32'h1234_5678, 32'h7777_7777, 1'b0, 0, 32'h0,         1'b0};
      tbl[4] = '{32'hFFFF_FFFC, 1'b0, 4'h5, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 32'hCAFE_F00D, 1'b0};
      tbl[5] = '{32'h0000_0020, 1'b1, 4'hF, 32'h0F0F_0F0F, 32'h9999_9999, 1'b1, 0, 32'h0,         1'b1};

      rst_i       = 1'b1;
      obi_req_i   = 1'b0;
      obi_addr_i  = '0;
      obi_we_i    = 1'b0;
      obi_be_i    = '0;
      obi_wdata_i = '0;
      reg_rsp     = '0;

      tick();
      obi_req_i = 1'b1;
      tick();
      chk("reset_gnt", 64'(obi_gnt_o), 64'd0);
      chk("reset_reg_req", 64'({reg_req.valid, reg_req.write, reg_req.wstrb}), 64'd0);
      chk("reset_reg_addr", 64'({reg_req.addr, reg_req.wdata}), 64'd0);
      chk("reset_rvalid", 64'(obi_rvalid_o), 64'd0);
      obi_req_i = 1'b0;
      rst_i     = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         do_txn(tbl[i], 1'b0);
         tick();
      end

      // Back-to-back: second grant exactly one cycle after the first rvalid.
      do_txn(tbl[0], 1'b1);
      do_txn(tbl[4], 1'b0);

      // Stray ready while idle.
      reg_rsp.ready = 1'b1;
      reg_rsp.rdata = 32'h1357_9BDF;
      tick();
      tick();
      chk("stray_ready_valid", 64'(reg_req.valid), 64'd0);
      chk("stray_ready_rvalid", 64'(obi_rvalid_o), 64'd0);
      reg_rsp = '0;

      // Reset during ACCESS drops the transaction.
      obi_req_i   = 1'b1;
      obi_addr_i  = 32'h0000_0040;
      obi_we_i    = 1'b0;
      obi_be_i    = 4'hF;
      chk("rst_gnt", 64'(obi_gnt_o), 64'd1);
      tick();
      obi_req_i = 1'b0;
      chk("rst_acc_valid", 64'(reg_req.valid), 64'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("rst_valid_drop", 64'(reg_req.valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         chk("rst_no_rvalid", 64'(obi_rvalid_o), 64'd0);
         tick();
      end
      do_txn(tbl[2], 1'b0);

`ifdef BITREV_OBI_REG_TIMEOUT_EN
      begin
         vec_t tv;
         tv = '{32'h0000_0044, 1'b0, 4'hF, 32'h0, 32'hAAAA_5555, 1'b0, -1, 32'h0, 1'b1};
         do_txn(tv, 1'b0);
         tick();
         tv = '{32'h0000_0048, 1'b0, 4'hF, 32'h0, 32'h2468_ACE0, 1'b0, TO - 1, 32'h2468_ACE0, 1'b0};
         do_txn(tv, 1'b0);
      end
`endif

      tick();
      tick();
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
